// File: rtl/syscall_unit.sv
// Syscall handler: halt / display / pause services and the core-wide stall.
// Optional retired-syscall counter built when SYSCALL_COUNTER_EN is defined.
module syscall_unit #(
  parameter int          CNT_W     = 16,
  parameter logic [31:0] SVC_HALT  = 32'd10,
  parameter logic [31:0] SVC_DISP  = 32'd34,
  parameter logic [31:0] SVC_PAUSE = 32'd50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             syscall_en,
  input  logic [31:0]      v0,
  input  logic [31:0]      a0,
  input  logic             resume,
  output logic             stall,
  output logic             halted,
  output logic [31:0]      disp_data,
  output logic             disp_valid,
  output logic [CNT_W-1:0] syscall_count
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PAUSE = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   resume_q;
  logic   accept;
  logic   resume_rise;

  assign accept      = en & syscall_en & (state == RUN);
  assign resume_rise = resume & ~resume_q;
  assign stall       = (state != RUN);
  assign halted      = (state == HALT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      resume_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      resume_q <= resume;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (accept) begin
          if (v0 == SVC_HALT)       state_nxt = HALT;
          else if (v0 == SVC_PAUSE) state_nxt = PAUSE;
        end
      end
      PAUSE:   if (resume_rise) state_nxt = RUN;
      HALT:    state_nxt = HALT;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_data  <= '0;
      disp_valid <= 1'b0;
    end else begin
      disp_valid <= accept && (v0 == SVC_DISP);
      if (accept && (v0 == SVC_DISP)) disp_data <= a0;
    end
  end

`ifdef SYSCALL_COUNTER_EN
  logic [CNT_W-1:0] cnt;

  // Saturates so a long-running program never wraps the debug count back to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       cnt <= '0;
    else if (accept && (cnt != '1)) cnt <= cnt + 1'b1;
  end

  assign syscall_count = cnt;
`else
  assign syscall_count = '0;
`endif

endmodule
